alu: RTL and testbench

//   Registered WIDTH-bit integer ALU: add, sub, AND, OR, XOR, shift-left,

---
 rtl/alu.sv | 101 ++++++++++
 tb/tb_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu - registered WIDTH-bit integer ALU for the execute stage.
//
// The block samples the operands and the opcode on every rising clock edge.
// The result and the flags appear one cycle later. There is no handshake.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset; clears all outputs
//   A, B     - WIDTH-bit operands
//   alu_ctrl - 3-bit opcode (ADD SUB AND OR XOR SHL SHR SLT)
//   result   - registered WIDTH-bit result
//   zero     - registered: result == 0
//   carry    - registered: add carry-out, sub borrow, or shifted-out bit
//   overflow - registered: signed overflow for ADD/SUB, otherwise 0
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    // The add and subtract paths are one bit wider than the operands.
    // For the sum, the extra bit is the carry-out.
    // For the difference, the extra bit is the unsigned borrow (A < B).
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_n;
    logic             c_n;
    logic             v_n;
    logic             lt_s;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign lt_s = $signed(A) < $signed(B);

    always_comb begin
        res_n = '0;
        c_n   = 1'b0;
        v_n   = 1'b0;
        case (op_e'(alu_ctrl))
            OP_ADD: begin
                res_n = sum[MSB:0];
                c_n   = sum[WIDTH];
                v_n   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                res_n = diff[MSB:0];
                c_n   = diff[WIDTH];
                v_n   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_AND: res_n = A & B;
            OP_OR:  res_n = A | B;
            OP_XOR: res_n = A ^ B;
            OP_SHL: begin
                res_n = {A[MSB-1:0], 1'b0};
                c_n   = A[MSB];
            end
            OP_SHR: begin
                res_n = {1'b0, A[MSB:1]};
                c_n   = A[0];
            end
            OP_SLT: res_n = {{(WIDTH-1){1'b0}}, lt_s};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            result   <= res_n;
            zero     <= (res_n == '0);
            carry    <= c_n;
            overflow <= v_n;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu - self-checking bench for alu (WIDTH=8).
//
// Each stimulus is driven on the falling edge of the clock.
// A reference model computes the expected outputs from plain integer arithmetic.
// Those expected outputs are pushed onto a queue.
// After the next rising edge, the bench pops the queue and compares the DUT outputs.
module tb_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   alu_ctrl = '0;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];

    alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .alu_ctrl(alu_ctrl),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // The reference model works on integers and range checks.
    // It does not use bit tricks, so it stays independent of the RTL.
    function automatic exp_t model(input string tag, input int ua, input int ub, input int op);
        exp_t e;
        int sa, sb_, t;
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb_ = (ub >= 128) ? ub - 256 : ub;
        e.tag = tag;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            0: begin
                t = ua + ub;
                e.r = t[W-1:0];
                e.c = (t >= 256);
                e.v = (sa + sb_ > 127) || (sa + sb_ < -128);
            end
            1: begin
                t = ua - ub + 256;
                e.r = t[W-1:0];
                e.c = (ua < ub);
                e.v = (sa - sb_ > 127) || (sa - sb_ < -128);
            end
            2: begin t = ua & ub; e.r = t[W-1:0]; end
            3: begin t = ua | ub; e.r = t[W-1:0]; end
            4: begin t = ua ^ ub; e.r = t[W-1:0]; end
            5: begin
                t = (ua * 2) % 256;
                e.r = t[W-1:0];
                e.c = (ua >= 128);
            end
            6: begin
                t = ua / 2;
                e.r = t[W-1:0];
                e.c = (ua % 2) == 1;
            end
            default: begin
                t = (sa < sb_) ? 1 : 0;
                e.r = t[W-1:0];
            end
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".result"}, 32'(result), 32'(e.r));
            chk({e.tag, ".zero"}, 32'(zero), 32'(e.z));
            chk({e.tag, ".carry"}, 32'(carry), 32'(e.c));
            chk({e.tag, ".ovf"}, 32'(overflow), 32'(e.v));
        end
    endtask

    task automatic apply(input string tag, input int a, input int b, input int op);
        @(negedge clk);
        A = a[W-1:0];
        B = b[W-1:0];
        alu_ctrl = op[2:0];
        sb.push_back(model(tag, a, b, op));
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".result"}, 32'(result), 32'd0);
        chk({tag, ".zero"}, 32'(zero), 32'd0);
        chk({tag, ".carry"}, 32'(carry), 32'd0);
        chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        // Reset is held through a rising edge with non-zero inputs applied.
        // The outputs must stay cleared while reset is low.
        A = 8'h55;
        B = 8'h33;
        alu_ctrl = 3'b000;
        @(posedge clk);
        #1;
        check_cleared("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        apply("add_10_5", 10, 5, 0);
        apply("add_250_10", 250, 10, 0);
        apply("add_127_1", 127, 1, 0);
        apply("sub_80_1", 8'h80, 1, 1);
        apply("sub_10_5", 10, 5, 1);
        apply("and", 8'h0C, 8'h0A, 2);
        apply("or", 8'h0C, 8'h0A, 3);
        apply("xor", 8'h0C, 8'h0A, 4);
        apply("shl", 8'h0C, 8'h0A, 5);
        apply("shr", 8'h0C, 8'h0A, 6);
        apply("slt_3_7", 3, 7, 7);
        apply("slt_m1_1", 8'hFF, 1, 7);
        apply("slt_7_3", 7, 3, 7);
        apply("sub_5_5", 5, 5, 1);
        apply("sub_0_1", 0, 1, 1);
        apply("shl_80", 8'h80, 0, 5);
        apply("shr_01", 8'h01, 8'hFF, 6);
        apply("add_80_80", 8'h80, 8'h80, 0);

        // Reset is asserted between clock edges, in the middle of the stream.
        // The outputs must clear at once, without waiting for a clock edge.
        apply("pre_rst", 8'hF0, 8'h0F, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 8'h12, 8'h34, 0);

        for (int i = 0; i < 60; i++) begin
            apply("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net: if the run is still going after this bound, stop with a failure.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
